// File: rtl/id_exe_stage_reg.sv
// ID/EXE pipeline register with load-use hazard detection; one cycle from ID to EXE outputs.
// Backpressure: freeze holds everything, hazard_stall (combinational) holds PC and IF/ID for one cycle.
module id_exe_stage_reg #(
  parameter int DATA_W = 32,
  parameter int REG_W  = 5,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              freeze,
  input  logic              flush,
  input  logic              id_valid,
  input  logic [DATA_W-1:0] id_pc,
  input  logic [DATA_W-1:0] id_val1,
  input  logic [DATA_W-1:0] id_val2,
  input  logic [DATA_W-1:0] id_st_val,
  input  logic [REG_W-1:0]  id_src1,
  input  logic [REG_W-1:0]  id_src2,
  input  logic [REG_W-1:0]  id_dest,
  input  logic              id_src2_used,
  input  logic              id_wb_en,
  input  logic              id_mem_r_en,
  input  logic              id_mem_w_en,
  input  logic              id_is_imm,
  input  logic [3:0]        id_exe_cmd,
  input  logic [1:0]        id_br_type,
  output logic              exe_valid,
  output logic [DATA_W-1:0] exe_pc,
  output logic [DATA_W-1:0] exe_val1,
  output logic [DATA_W-1:0] exe_val2,
  output logic [DATA_W-1:0] exe_st_val,
  output logic [REG_W-1:0]  exe_src1,
  output logic [REG_W-1:0]  exe_src2,
  output logic [REG_W-1:0]  exe_dest,
  output logic              exe_wb_en,
  output logic              exe_mem_r_en,
  output logic              exe_mem_w_en,
  output logic              exe_is_imm,
  output logic [3:0]        exe_exe_cmd,
  output logic [1:0]        exe_br_type,
  output logic              hazard_stall,
  output logic [CNT_W-1:0]  bubble_count
);

  logic luh;
  logic src_match;
  logic ctl_keep;

  // Register 0 is hardwired, so a load targeting it can never create a dependency.
  always_comb begin
    src_match = (id_src1 == exe_dest) | (id_src2_used & (id_src2 == exe_dest));
    luh       = exe_valid & exe_mem_r_en & (exe_dest != '0) & id_valid & src_match;
  end

  assign hazard_stall = luh & ~flush & ~freeze;
  assign ctl_keep     = id_valid;

  always_ff @(posedge clk) begin
    if (!rst) begin
      exe_valid    <= 1'b0;
      exe_pc       <= '0;
      exe_val1     <= '0;
      exe_val2     <= '0;
      exe_st_val   <= '0;
      exe_src1     <= '0;
      exe_src2     <= '0;
      exe_dest     <= '0;
      exe_wb_en    <= 1'b0;
      exe_mem_r_en <= 1'b0;
      exe_mem_w_en <= 1'b0;
      exe_is_imm   <= 1'b0;
      exe_exe_cmd  <= '0;
      exe_br_type  <= '0;
      bubble_count <= '0;
    end else if (!freeze) begin
      if (flush | luh) begin
        exe_valid    <= 1'b0;
        exe_pc       <= '0;
        exe_val1     <= '0;
        exe_val2     <= '0;
        exe_st_val   <= '0;
        exe_src1     <= '0;
        exe_src2     <= '0;
        exe_dest     <= '0;
        exe_wb_en    <= 1'b0;
        exe_mem_r_en <= 1'b0;
        exe_mem_w_en <= 1'b0;
        exe_is_imm   <= 1'b0;
        exe_exe_cmd  <= '0;
        exe_br_type  <= '0;
        // Only load-use bubbles are counted; a flush discards the ID instruction outright.
        if (!flush && (bubble_count != {CNT_W{1'b1}}))
          bubble_count <= bubble_count + 1'b1;
      end else begin
        exe_valid    <= id_valid;
        exe_pc       <= id_pc;
        exe_val1     <= id_val1;
        exe_val2     <= id_val2;
        exe_st_val   <= id_st_val;
        exe_src1     <= id_src1;
        exe_src2     <= id_src2;
        exe_dest     <= id_dest;
        exe_wb_en    <= id_wb_en & ctl_keep;
        exe_mem_r_en <= id_mem_r_en & ctl_keep;
        exe_mem_w_en <= id_mem_w_en & ctl_keep;
        exe_is_imm   <= id_is_imm & ctl_keep;
        exe_exe_cmd  <= ctl_keep ? id_exe_cmd : 4'd0;
        exe_br_type  <= ctl_keep ? id_br_type : 2'd0;
      end
    end
  end

endmodule

// File: tb/tb_id_exe_stage_reg.sv
// Directed bench for id_exe_stage_reg; counter width reduced to 2 so saturation is reachable.
module tb_id_exe_stage_reg;
  localparam int DW = 32;
  localparam int RW = 5;
  localparam int CW = 2;

  logic clk = 1'b0;
  logic rst, freeze, flush;
  logic id_valid, id_src2_used, id_wb_en, id_mem_r_en, id_mem_w_en, id_is_imm;
  logic [DW-1:0] id_pc, id_val1, id_val2, id_st_val;
  logic [RW-1:0] id_src1, id_src2, id_dest;
  logic [3:0] id_exe_cmd;
  logic [1:0] id_br_type;
  logic exe_valid, exe_wb_en, exe_mem_r_en, exe_mem_w_en, exe_is_imm, hazard_stall;
  logic [DW-1:0] exe_pc, exe_val1, exe_val2, exe_st_val;
  logic [RW-1:0] exe_src1, exe_src2, exe_dest;
  logic [3:0] exe_exe_cmd;
  logic [1:0] exe_br_type;
  logic [CW-1:0] bubble_count;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  id_exe_stage_reg #(.DATA_W(DW), .REG_W(RW), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
    .id_valid(id_valid), .id_pc(id_pc), .id_val1(id_val1), .id_val2(id_val2),
    .id_st_val(id_st_val), .id_src1(id_src1), .id_src2(id_src2), .id_dest(id_dest),
    .id_src2_used(id_src2_used), .id_wb_en(id_wb_en), .id_mem_r_en(id_mem_r_en),
    .id_mem_w_en(id_mem_w_en), .id_is_imm(id_is_imm), .id_exe_cmd(id_exe_cmd),
    .id_br_type(id_br_type),
    .exe_valid(exe_valid), .exe_pc(exe_pc), .exe_val1(exe_val1), .exe_val2(exe_val2),
    .exe_st_val(exe_st_val), .exe_src1(exe_src1), .exe_src2(exe_src2), .exe_dest(exe_dest),
    .exe_wb_en(exe_wb_en), .exe_mem_r_en(exe_mem_r_en), .exe_mem_w_en(exe_mem_w_en),
    .exe_is_imm(exe_is_imm), .exe_exe_cmd(exe_exe_cmd), .exe_br_type(exe_br_type),
    .hazard_stall(hazard_stall), .bubble_count(bubble_count)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Valid instruction with wb_en=1; other controls cleared, data derived from pc.
  task automatic ins(input logic [DW-1:0] pc, input logic [RW-1:0] s1, input logic [RW-1:0] s2,
                     input logic s2u, input logic [RW-1:0] d, input logic mr, input logic [3:0] cmd);
    id_valid = 1'b1; id_pc = pc; id_val1 = pc + 1; id_val2 = pc + 2; id_st_val = pc + 3;
    id_src1 = s1; id_src2 = s2; id_src2_used = s2u; id_dest = d;
    id_wb_en = 1'b1; id_mem_r_en = mr; id_mem_w_en = 1'b0; id_is_imm = 1'b0;
    id_exe_cmd = cmd; id_br_type = 2'd0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; freeze = 1'b0; flush = 1'b0;
    ins($urandom, 5'($urandom), 5'($urandom), 1'b1, 5'($urandom), 1'b1, 4'($urandom));
    id_br_type = 2'd3; id_mem_w_en = 1'b1;
    tick();
    ins($urandom, 5'($urandom), 5'($urandom), 1'b1, 5'($urandom), 1'b1, 4'($urandom));
    tick();
    chk("rst_valid", exe_valid, 0);
    chk("rst_pc", exe_pc, 0);
    chk("rst_mem_r", exe_mem_r_en, 0);
    chk("rst_dest", exe_dest, 0);
    chk("rst_br", exe_br_type, 0);
    chk("rst_cnt", bubble_count, 0);
    chk("rst_stall", hazard_stall, 0);

    // Load-use on src1
    rst = 1'b1;
    ins(32'h100, 5'd2, 5'd3, 1'b0, 5'd5, 1'b1, 4'd1);
    tick();
    chk("ld_pc", exe_pc, 32'h100);
    chk("ld_mem_r", exe_mem_r_en, 1);
    chk("ld_dest", exe_dest, 5);
    ins(32'h104, 5'd5, 5'd0, 1'b0, 5'd6, 1'b0, 4'd2);
    id_br_type = 2'd2;
    #1;
    chk("lu_stall", hazard_stall, 1);
    tick();
    chk("bub_valid", exe_valid, 0);
    chk("bub_pc", exe_pc, 0);
    chk("bub_cnt", bubble_count, 1);
    chk("bub_stall", hazard_stall, 0);
    tick();
    chk("use_src1", exe_src1, 5);
    chk("use_pc", exe_pc, 32'h104);
    chk("use_valid", exe_valid, 1);
    chk("use_cmd", exe_exe_cmd, 2);
    chk("use_br", exe_br_type, 2);
    chk("use_val2", exe_val2, 32'h106);

    // Load to r0 never stalls
    ins(32'h108, 5'd1, 5'd1, 1'b0, 5'd0, 1'b1, 4'd1);
    tick();
    ins(32'h10c, 5'd0, 5'd0, 1'b1, 5'd1, 1'b0, 4'd3);
    #1;
    chk("r0_stall", hazard_stall, 0);
    tick();
    chk("r0_pc", exe_pc, 32'h10c);
    chk("r0_cnt", bubble_count, 1);

    // src2 matters only when used; flush beats the hazard
    ins(32'h110, 5'd1, 5'd1, 1'b0, 5'd7, 1'b1, 4'd1);
    tick();
    ins(32'h114, 5'd1, 5'd7, 1'b0, 5'd2, 1'b0, 4'd3);
    #1;
    chk("s2unused_stall", hazard_stall, 0);
    id_src2_used = 1'b1;
    #1;
    chk("s2used_stall", hazard_stall, 1);
    flush = 1'b1;
    #1;
    chk("flush_stall", hazard_stall, 0);
    tick();
    flush = 1'b0;
    chk("flush_valid", exe_valid, 0);
    chk("flush_pc", exe_pc, 0);
    chk("flush_cnt", bubble_count, 1);

    // Non-load producer passes straight through
    ins(32'h118, 5'd1, 5'd1, 1'b0, 5'd3, 1'b0, 4'd5);
    tick();
    ins(32'h11c, 5'd3, 5'd0, 1'b0, 5'd4, 1'b0, 4'd6);
    id_is_imm = 1'b1;
    #1;
    chk("add_stall", hazard_stall, 0);
    tick();
    chk("add_pc", exe_pc, 32'h11c);
    chk("add_src1", exe_src1, 3);
    chk("add_imm", exe_is_imm, 1);
    chk("add_cmd", exe_exe_cmd, 6);

    // Freeze holds everything and masks the stall
    ins(32'h120, 5'd1, 5'd1, 1'b0, 5'd9, 1'b1, 4'd1);
    tick();
    freeze = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ins(32'h124 + 4 * i, 5'd9, 5'd0, 1'b0, 5'd8, 1'b0, 4'd7);
      #1;
      chk("frz_stall", hazard_stall, 0);
      tick();
      chk("frz_pc", exe_pc, 32'h120);
      chk("frz_mem_r", exe_mem_r_en, 1);
      chk("frz_cnt", bubble_count, 1);
    end
    freeze = 1'b0;
    #1;
    chk("unfrz_stall", hazard_stall, 1);
    tick();
    chk("unfrz_bub", exe_valid, 0);
    chk("unfrz_cnt", bubble_count, 2);
    tick();
    chk("unfrz_pc", exe_pc, 32'h12c);
    chk("unfrz_cmd", exe_exe_cmd, 7);

    // Plain freeze release loads ID on first edge
    freeze = 1'b1;
    ins(32'h140, 5'd1, 5'd2, 1'b1, 5'd3, 1'b0, 4'd4);
    tick();
    chk("frz2_pc", exe_pc, 32'h12c);
    freeze = 1'b0;
    tick();
    chk("rel_pc", exe_pc, 32'h140);
    chk("rel_cmd", exe_exe_cmd, 4);

    // Invalid ID: controls zeroed, data captured
    ins(32'h200, 5'd4, 5'd5, 1'b1, 5'd6, 1'b1, 4'd7);
    id_valid = 1'b0; id_mem_w_en = 1'b1; id_is_imm = 1'b1; id_br_type = 2'd3;
    tick();
    chk("inv_valid", exe_valid, 0);
    chk("inv_wb", exe_wb_en, 0);
    chk("inv_mem_r", exe_mem_r_en, 0);
    chk("inv_mem_w", exe_mem_w_en, 0);
    chk("inv_br", exe_br_type, 0);
    chk("inv_cmd", exe_exe_cmd, 0);
    chk("inv_pc", exe_pc, 32'h200);
    chk("inv_dest", exe_dest, 6);

    // Two more stalls: 2 -> 3 -> saturated at 3
    for (int k = 0; k < 2; k++) begin
      ins(32'h300, 5'd1, 5'd1, 1'b0, 5'd5, 1'b1, 4'd1);
      tick();
      ins(32'h304, 5'd1, 5'd5, 1'b1, 5'd6, 1'b0, 4'd2);
      #1;
      chk("sat_stall", hazard_stall, 1);
      tick();
      chk("sat_cnt", bubble_count, 3);
      tick();
      chk("sat_pc", exe_pc, 32'h304);
    end

    // Reset in the middle of a stall
    ins(32'h400, 5'd1, 5'd1, 1'b0, 5'd5, 1'b1, 4'd1);
    tick();
    ins(32'h404, 5'd5, 5'd0, 1'b0, 5'd6, 1'b0, 4'd2);
    #1;
    chk("mid_stall", hazard_stall, 1);
    rst = 1'b0;
    tick();
    chk("mid_valid", exe_valid, 0);
    chk("mid_cnt", bubble_count, 0);
    chk("mid_stall_drop", hazard_stall, 0);
    rst = 1'b1;
    tick();
    chk("post_pc", exe_pc, 32'h404);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
